// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-buffer slice.
//  DEF_DATA_BITS      default byte width
//  ENTRY_W            stored entry width: {frame_error, parity_error, data}
//  PERR_BIT/FERR_BIT  flag positions inside a stored entry
//  DEF_TIMEOUT_TICKS  default inactivity timeout (4 chars x 10 bits x 16 ticks)
// The helper functions compute the same layout for a non-default data width.
package uart_pkg;

    localparam int DEF_DATA_BITS     = 8;
    localparam int ENTRY_W           = DEF_DATA_BITS + 2;
    localparam int PERR_BIT          = DEF_DATA_BITS;
    localparam int FERR_BIT          = DEF_DATA_BITS + 1;
    localparam int DEF_TIMEOUT_TICKS = 640;

    function automatic int entry_w(input int data_bits);
        return data_bits + 2;
    endfunction

    function automatic int perr_bit(input int data_bits);
        return data_bits;
    endfunction

    function automatic int ferr_bit(input int data_bits);
        return data_bits + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO.
//  clk    in   system clock
//  we     in   write enable
//  waddr  in   write address
//  wdata  in   write data
//  raddr  in   read address
//  rdata  out  read data, combinational from raddr (first-word-fall-through)
// Contents are intentionally not reset.
module uart_fifo_mem #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT FIFO of bytes plus per-byte
// parity/frame error flags, with fill threshold, sticky overrun and
// character-timeout flags.
//  clk, reset_n                     clock, asynchronous active-low reset
//  baud_x16_tick                    16x baud tick for the timeout counter
//  rx_data, rx_valid,
//  parity_error, frame_error        receiver side write strobe and payload
//  rd_en                            pop the head entry
//  rd_data, rd_parity_err,
//  rd_frame_err                     head entry (valid while empty=0)
//  empty, full, count               registered fill status
//  threshold, thresh_hit            thresh_hit = count >= threshold
//  overrun, overrun_clr             sticky drop flag and its clear
//  rx_timeout                       non-empty and idle for TIMEOUT_TICKS ticks
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_x16_tick,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    input  logic                 parity_error,
    input  logic                 frame_error,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_parity_err,
    output logic                 rd_frame_err,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_W:0]      count,
    input  logic [ADDR_W:0]      threshold,
    output logic                 thresh_hit,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 rx_timeout
);

    localparam int EW = entry_w(DATA_BITS);
    localparam int PB = perr_bit(DATA_BITS);
    localparam int FB = ferr_bit(DATA_BITS);
    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic              empty_reg, full_reg, thresh_reg, overrun_reg;
    logic [TW-1:0]     tmo_reg, tmo_next;
    logic              do_push, do_pop, overrun_next;
    logic [EW-1:0]     head_entry;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a
    // byte when it is being read.
    assign do_pop  = rd_en && !empty_reg;
    assign do_push = rx_valid && (!full_reg || do_pop);

    always_comb begin
        count_next = count_reg + CW'(do_push) - CW'(do_pop);

        // Set has priority over clear.
        overrun_next = overrun_reg;
        if (rx_valid && !do_push) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end

        tmo_next = tmo_reg;
        if (do_push || do_pop || empty_reg) begin
            tmo_next = '0;
        end else if (baud_x16_tick && (tmo_reg != TW'(TIMEOUT_TICKS))) begin
            tmo_next = tmo_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            empty_reg   <= 1'b1;
            full_reg    <= 1'b0;
            thresh_reg  <= 1'b0;
            overrun_reg <= 1'b0;
            tmo_reg     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg   <= count_next;
            empty_reg   <= (count_next == '0);
            full_reg    <= (count_next == CW'(DEPTH));
            thresh_reg  <= (count_next >= threshold);
            overrun_reg <= overrun_next;
            tmo_reg     <= tmo_next;
        end
    end

    uart_fifo_mem #(
        .WIDTH  (EW),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr_reg),
        .wdata ({frame_error, parity_error, rx_data}),
        .raddr (rd_ptr_reg),
        .rdata (head_entry)
    );

    assign rd_data       = head_entry[DATA_BITS-1:0];
    assign rd_parity_err = head_entry[PB];
    assign rd_frame_err  = head_entry[FB];
    assign empty         = empty_reg;
    assign full          = full_reg;
    assign count         = count_reg;
    assign thresh_hit    = thresh_reg;
    assign overrun       = overrun_reg;
    assign rx_timeout    = (tmo_reg == TW'(TIMEOUT_TICKS));

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic       baud_x16_tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       frame_error;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_parity_err;
    logic       rd_frame_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] threshold;
    logic       thresh_hit;
    logic       overrun;
    logic       overrun_clr;
    logic       rx_timeout;

    int checks;
    int failures;

    uart_rx_fifo dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud_x16_tick (baud_x16_tick),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_frame_err  (rd_frame_err),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .threshold     (threshold),
        .thresh_hit    (thresh_hit),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .rx_timeout    (rx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic pe, input logic fe);
        rx_data = b; parity_error = pe; frame_error = fe; rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0; parity_error = 1'b0; frame_error = 1'b0;
        $display("push data=%02h pe=%0d fe=%0d count=%0d", b, pe, fe, count);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        $display("pop count=%0d", count);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle();
        checks += 5;
        if (empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        if (full !== 1'b0)       begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        if (count !== 5'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        if (rx_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", rx_timeout); end
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_order();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        for (int i = 0; i < 3; i++) push(exp_b[i], 1'b0, 1'b0);
        checks += 2;
        if (count !== 5'd3) begin failures++; $display("FAIL order_count got=%0d exp=3", count); end
        if (empty !== 1'b0) begin failures++; $display("FAIL order_nonempty got=%0b exp=0", empty); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (rd_data !== exp_b[i]) begin failures++; $display("FAIL order_data[%0d] got=%02h exp=%02h", i, rd_data, exp_b[i]); end
            pop();
            if (count !== 5'(2 - i)) begin failures++; $display("FAIL order_count_pop[%0d] got=%0d exp=%0d", i, count, 2 - i); end
        end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL order_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_errors();
        push(8'h55, 1'b1, 1'b0);
        push(8'hAA, 1'b0, 1'b1);
        checks += 3;
        if (rd_data !== 8'h55)      begin failures++; $display("FAIL err_data0 got=%02h exp=55", rd_data); end
        if (rd_parity_err !== 1'b1) begin failures++; $display("FAIL err_perr0 got=%0b exp=1", rd_parity_err); end
        if (rd_frame_err !== 1'b0)  begin failures++; $display("FAIL err_ferr0 got=%0b exp=0", rd_frame_err); end
        pop();
        checks += 3;
        if (rd_data !== 8'hAA)      begin failures++; $display("FAIL err_data1 got=%02h exp=aa", rd_data); end
        if (rd_parity_err !== 1'b0) begin failures++; $display("FAIL err_perr1 got=%0b exp=0", rd_parity_err); end
        if (rd_frame_err !== 1'b1)  begin failures++; $display("FAIL err_ferr1 got=%0b exp=1", rd_frame_err); end
        pop();
    endtask

    task automatic test_overrun();
        // Pointers start at 5 here, so draining 16 entries crosses the wrap.
        for (int i = 1; i <= 16; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
        checks += 3;
        if (full !== 1'b1)     begin failures++; $display("FAIL ovr_full got=%0b exp=1", full); end
        if (count !== 5'd16)   begin failures++; $display("FAIL ovr_count16 got=%0d exp=16", count); end
        if (overrun !== 1'b0)  begin failures++; $display("FAIL ovr_early got=%0b exp=0", overrun); end
        push(8'h99, 1'b0, 1'b0);
        checks += 2;
        if (overrun !== 1'b1)  begin failures++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
        if (count !== 5'd16)   begin failures++; $display("FAIL ovr_count17 got=%0d exp=16", count); end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (rd_data !== 8'(8'h10 + i)) begin failures++; $display("FAIL ovr_data[%0d] got=%02h exp=%02h", i, rd_data, 8'(8'h10 + i)); end
            pop();
        end
        checks += 2;
        if (empty !== 1'b1)    begin failures++; $display("FAIL ovr_drained got=%0b exp=1", empty); end
        if (overrun !== 1'b1)  begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0)  begin failures++; $display("FAIL ovr_clr got=%0b exp=0", overrun); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i), 1'b0, 1'b0);
        rx_data = 8'hEE; rx_valid = 1'b1; rd_en = 1'b1;
        cycle();
        rx_valid = 1'b0; rd_en = 1'b0;
        $display("push+pop data=ee count=%0d", count);
        checks += 3;
        if (count !== 5'd16)  begin failures++; $display("FAIL b2b_count got=%0d exp=16", count); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
        if (full !== 1'b1)    begin failures++; $display("FAIL b2b_full got=%0b exp=1", full); end
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 16) ? 8'hEE : 8'(8'h60 + i);
            checks++;
            if (rd_data !== exp_b) begin failures++; $display("FAIL b2b_data[%0d] got=%02h exp=%02h", i, rd_data, exp_b); end
            pop();
        end
    endtask

    task automatic test_threshold();
        threshold = 5'd4;
        for (int i = 0; i < 3; i++) push(8'(i), 1'b0, 1'b0);
        checks++;
        if (thresh_hit !== 1'b0) begin failures++; $display("FAIL thr_below got=%0b exp=0", thresh_hit); end
        push(8'h03, 1'b0, 1'b0);
        checks++;
        if (thresh_hit !== 1'b1) begin failures++; $display("FAIL thr_hit got=%0b exp=1", thresh_hit); end
        pop();
        checks++;
        if (thresh_hit !== 1'b0) begin failures++; $display("FAIL thr_drop got=%0b exp=0", thresh_hit); end
        for (int i = 0; i < 3; i++) pop();
        threshold = 5'd0;
        cycle();
        checks++;
        if (thresh_hit !== 1'b1) begin failures++; $display("FAIL thr_zero got=%0b exp=1", thresh_hit); end
        threshold = 5'd16;
        cycle();
    endtask

    task automatic test_timeout();
        push(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 639; i++) begin
            baud_x16_tick = 1'b1; cycle();
            baud_x16_tick = 1'b0; cycle();
        end
        checks++;
        if (rx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%0b exp=0", rx_timeout); end
        baud_x16_tick = 1'b1; cycle();
        baud_x16_tick = 1'b0; cycle();
        checks++;
        if (rx_timeout !== 1'b1) begin failures++; $display("FAIL tmo_set got=%0b exp=1", rx_timeout); end
        for (int i = 0; i < 5; i++) begin
            baud_x16_tick = 1'b1; cycle();
            baud_x16_tick = 1'b0; cycle();
        end
        checks++;
        if (rx_timeout !== 1'b1) begin failures++; $display("FAIL tmo_saturate got=%0b exp=1", rx_timeout); end
        pop();
        checks++;
        if (rx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%0b exp=0", rx_timeout); end
    endtask

    task automatic test_midstream_reset();
        threshold = 5'd2;
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i), 1'b0, 1'b0);
        checks += 2;
        if (overrun !== 1'b1 || full !== 1'b1) begin failures++; $display("FAIL rst_pre got=ovr%0b/full%0b exp=1/1", overrun, full); end
        if (thresh_hit !== 1'b1) begin failures++; $display("FAIL rst_pre_thr got=%0b exp=1", thresh_hit); end
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (empty !== 1'b1)      begin failures++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        if (full !== 1'b0)       begin failures++; $display("FAIL rst_full got=%0b exp=0", full); end
        if (count !== 5'd0)      begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        if (overrun !== 1'b0)    begin failures++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
        if (thresh_hit !== 1'b0) begin failures++; $display("FAIL rst_thr got=%0b exp=0", thresh_hit); end
        cycle();
        reset_n = 1'b1;
        threshold = 5'd16;
        cycle();
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL rst_after got=%0b exp=1", empty); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0; baud_x16_tick = 1'b0; rx_data = '0; rx_valid = 1'b0;
        parity_error = 1'b0; frame_error = 1'b0; rd_en = 1'b0;
        threshold = 5'd16; overrun_clr = 1'b0;
        #3;
        test_reset();
        test_order();
        test_errors();
        test_overrun();
        test_back_to_back();
        test_threshold();
        test_timeout();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
